// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: handshake state encoding and default
// stage-boundary payload widths.
package pipe_pkg;

    localparam int INST_W  = 32;
    localparam int PC_W    = 32;
    localparam int IF_ID_W = INST_W + PC_W;

    // Encoded as {out_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b10,
        ST_SKID  = 2'b11
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance events.
// Ports: clk, rst (sync, active-high), inc, clr (priority over inc), count.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, one-entry skid
// buffer, synchronous flush and a saturating stall-cycle counter.
// Ports: clk, rst, flush; in_valid/in_ready/in_data upstream;
// out_valid/out_ready/out_data downstream; occupancy; stall_cnt/stall_clr.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = IF_ID_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    state_e            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              skid_valid;
    logic              in_fire;
    logic              out_fire;
    logic              stall;

    // Handshake flags come straight from state flops, so there is no
    // combinational path from any input to any output.
    assign out_valid  = state[1];
    assign skid_valid = state[0];
    assign in_ready   = ~skid_valid;
    assign out_data   = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign stall    = out_valid & ~out_ready;

    always_comb begin
        occupancy = 2'd0;
        unique case (state)
            ST_FULL: occupancy = 2'd1;
            ST_SKID: occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_EMPTY;
            main_q <= RESET_VAL;
        end else if (flush) begin
            // Held beats and any beat offered this cycle are dropped.
            state  <= ST_EMPTY;
            main_q <= RESET_VAL;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state  <= ST_FULL;
                        main_q <= in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new beat, main holds.
                        state  <= ST_SKID;
                        skid_q <= in_data;
                    end else if (out_fire) begin
                        // out_data keeps its last value while empty.
                        state <= ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (out_fire) begin
                        state  <= ST_FULL;
                        main_q <= skid_q;
                    end
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .clr   (stall_clr),
        .count (stall_cnt)
    );

    a_no_illegal_state: assert property (
        @(posedge clk) !(~out_valid & skid_valid)
    );

    a_main_held: assert property (
        @(posedge clk) disable iff (rst || flush)
        (out_valid && !out_ready) |=> (out_valid && $stable(main_q))
    );

    a_skid_held: assert property (
        @(posedge clk) disable iff (rst || flush)
        (skid_valid && !out_ready) |=> (skid_valid && $stable(skid_q))
    );

    a_accept_lands: assert property (
        @(posedge clk) disable iff (rst || flush)
        in_fire |=> out_valid
    );

endmodule
